// File: rtl/mips_defs.sv
// Shared opcode/funct constants, control codes and state encoding for the
// multi-cycle MIPS-subset controller.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_SLT, C_ORI, C_ADDIU, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_ILL
  } iclass_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       extop;
  } alu_sel_t;

  // ALU B-source/extension/operation held constant from EXE through WB.
  function automatic alu_sel_t alu_sel(iclass_t c);
    alu_sel_t s;
    s = '{aluop: ALU_ADD, alusrc: 1'b0, extop: 1'b0};
    case (c)
      C_ADDU:             s = '{aluop: ALU_ADD, alusrc: 1'b0, extop: 1'b0};
      C_SUBU:             s = '{aluop: ALU_SUB, alusrc: 1'b0, extop: 1'b0};
      C_SLT:              s = '{aluop: ALU_SLT, alusrc: 1'b0, extop: 1'b0};
      C_ORI:              s = '{aluop: ALU_OR,  alusrc: 1'b1, extop: 1'b0};
      C_LUI:              s = '{aluop: ALU_LUI, alusrc: 1'b1, extop: 1'b0};
      C_ADDIU, C_LW, C_SW: s = '{aluop: ALU_ADD, alusrc: 1'b1, extop: 1'b1};
      C_BEQ:              s = '{aluop: ALU_SUB, alusrc: 1'b0, extop: 1'b1};
      default:            s = '{aluop: ALU_ADD, alusrc: 1'b0, extop: 1'b0};
    endcase
    return s;
  endfunction

  function automatic logic is_rtype(iclass_t c);
    return (c == C_ADDU) || (c == C_SUBU) || (c == C_SLT);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decode into an instruction class; anything not in
// the supported subset maps to C_ILL.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] iclass
);

  always_comb begin
    iclass = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = C_ADDU;
          FN_SUBU: iclass = C_SUBU;
          FN_SLT:  iclass = C_SLT;
          default: iclass = C_ILL;
        endcase
      end
      OP_ORI:   iclass = C_ORI;
      OP_ADDIU: iclass = C_ADDIU;
      OP_LUI:   iclass = C_LUI;
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_BEQ:   iclass = C_BEQ;
      OP_J:     iclass = C_J;
      default:  iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences the shared datapath and counts
// retired instructions.
//
// state  | meaning
// FETCH  | read IR from memory, PC <= PC+4 once mem_rdy
// DECODE | j completes here; illegal op/funct flagged and dropped
// EXE    | ALU operation; beq resolves and completes here
// MEM    | lw/sw data access, held until mem_rdy
// WB     | register-file write, instruction retires
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       NPCOp,
  output logic [2:0]       ALUOp,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t     state_q, state_d;
  logic [3:0] cls_raw;
  iclass_t    cls;
  alu_sel_t   alu;
  logic [CNT_W-1:0] cnt_q;

  logic pcwr_c, irwr_c, regwr_c, memrd_c, memwr_c;
  logic ext_c, alusrc_c, regdst_c, memtoreg_c, retire_c, illegal_c;
  logic [1:0] npc_c;
  logic [2:0] aluop_c;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .iclass (cls_raw)
  );

  assign cls = iclass_t'(cls_raw);
  assign alu = alu_sel(cls);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwr_c     = 1'b0;
    irwr_c     = 1'b0;
    regwr_c    = 1'b0;
    memrd_c    = 1'b0;
    memwr_c    = 1'b0;
    ext_c      = 1'b0;
    alusrc_c   = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    npc_c      = NPC_PC4;
    aluop_c    = ALU_ADD;
    retire_c   = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        if (mem_rdy) begin
          pcwr_c  = 1'b1;
          irwr_c  = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls == C_J) begin
          pcwr_c   = 1'b1;
          npc_c    = NPC_JMP;
          retire_c = 1'b1;
        end else if (cls == C_ILL) begin
          illegal_c = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        aluop_c  = alu.aluop;
        alusrc_c = alu.alusrc;
        ext_c    = alu.extop;
        if (cls == C_BEQ) begin
          npc_c    = NPC_BR;
          pcwr_c   = zero;
          retire_c = 1'b1;
        end else if (cls == C_LW || cls == C_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        aluop_c  = alu.aluop;
        alusrc_c = alu.alusrc;
        ext_c    = alu.extop;
        if (cls == C_LW) memrd_c = 1'b1;
        else             memwr_c = 1'b1;
        // Request stays asserted until the memory acknowledges it.
        if (!mem_rdy)          state_d = S_MEM;
        else if (cls == C_LW)  state_d = S_WB;
        else                   retire_c = 1'b1;
      end
      S_WB: begin
        aluop_c    = alu.aluop;
        alusrc_c   = alu.alusrc;
        ext_c      = alu.extop;
        regwr_c    = 1'b1;
        retire_c   = 1'b1;
        regdst_c   = is_rtype(cls);
        memtoreg_c = (cls == C_LW);
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every output so nothing can write while rst_n is low.
  assign PCWr       = rst_n & pcwr_c;
  assign IRWr       = rst_n & irwr_c;
  assign RegWr      = rst_n & regwr_c;
  assign MemRd      = rst_n & memrd_c;
  assign MemWr      = rst_n & memwr_c;
  assign ExtOp      = rst_n & ext_c;
  assign ALUSrc     = rst_n & alusrc_c;
  assign RegDst     = rst_n & regdst_c;
  assign MemtoReg   = rst_n & memtoreg_c;
  assign retire     = rst_n & retire_c;
  assign illegal    = rst_n & illegal_c;
  assign NPCOp      = rst_n ? npc_c : 2'b00;
  assign ALUOp      = rst_n ? aluop_c : 3'b000;
  assign state      = state_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-phase behavioural model drives expected
// outputs, checked every cycle on two instances (CNT_W=32 and CNT_W=4).
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_rdy = 1'b1;

  logic a_pcwr, a_irwr, a_regwr, a_memrd, a_memwr, a_ext, a_asrc, a_rdst, a_m2r, a_ret, a_ill;
  logic [1:0] a_npc;
  logic [2:0] a_aluop, a_state;
  logic [31:0] a_cnt;
  logic b_pcwr, b_irwr, b_regwr, b_memrd, b_memwr, b_ext, b_asrc, b_rdst, b_m2r, b_ret, b_ill;
  logic [1:0] b_npc;
  logic [2:0] b_aluop, b_state;
  logic [3:0] b_cnt;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(a_pcwr), .IRWr(a_irwr), .RegWr(a_regwr), .MemRd(a_memrd), .MemWr(a_memwr),
    .ExtOp(a_ext), .ALUSrc(a_asrc), .RegDst(a_rdst), .MemtoReg(a_m2r), .NPCOp(a_npc),
    .ALUOp(a_aluop), .retire(a_ret), .illegal(a_ill), .state(a_state), .retire_cnt(a_cnt)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(b_pcwr), .IRWr(b_irwr), .RegWr(b_regwr), .MemRd(b_memrd), .MemWr(b_memwr),
    .ExtOp(b_ext), .ALUSrc(b_asrc), .RegDst(b_rdst), .MemtoReg(b_m2r), .NPCOp(b_npc),
    .ALUOp(b_aluop), .retire(b_ret), .illegal(b_ill), .state(b_state), .retire_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcwr, irwr, regwr, memrd, memwr, extop, alusrc, regdst, memtoreg;
    logic [1:0] npcop;
    logic [2:0] aluop;
    logic retire, illegal;
    logic [2:0] state;
  } vec_t;

  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_ORI, K_ADDIU, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;

  vec_t act_a, act_b, exp_v;
  assign act_a = {a_pcwr, a_irwr, a_regwr, a_memrd, a_memwr, a_ext, a_asrc, a_rdst, a_m2r,
                  a_npc, a_aluop, a_ret, a_ill, a_state};
  assign act_b = {b_pcwr, b_irwr, b_regwr, b_memrd, b_memwr, b_ext, b_asrc, b_rdst, b_m2r,
                  b_npc, b_aluop, b_ret, b_ill, b_state};

  int errors = 0, checks = 0, ncyc = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  // Expected outputs for one cycle of an instruction in a given phase.
  function automatic vec_t model(kind_t k, int ph, logic z, logic rdy);
    vec_t v;
    logic [2:0] aop;
    logic asrc, aext;
    v = '0;
    aop = 3'd0; asrc = 1'b0; aext = 1'b0;
    case (k)
      K_ADDU:              begin aop = 3'd0; asrc = 1'b0; aext = 1'b0; end
      K_SUBU:              begin aop = 3'd1; asrc = 1'b0; aext = 1'b0; end
      K_SLT:               begin aop = 3'd3; asrc = 1'b0; aext = 1'b0; end
      K_ORI:               begin aop = 3'd2; asrc = 1'b1; aext = 1'b0; end
      K_LUI:               begin aop = 3'd4; asrc = 1'b1; aext = 1'b0; end
      K_ADDIU, K_LW, K_SW: begin aop = 3'd0; asrc = 1'b1; aext = 1'b1; end
      K_BEQ:               begin aop = 3'd1; asrc = 1'b0; aext = 1'b1; end
      default: ;
    endcase
    v.state = 3'(ph);
    if (ph == P_FETCH) begin
      v.memrd = 1'b1;
      v.pcwr = rdy;
      v.irwr = rdy;
    end else if (ph == P_DECODE) begin
      if (k == K_J) begin v.pcwr = 1'b1; v.npcop = 2'b10; v.retire = 1'b1; end
      if (k == K_ILL) v.illegal = 1'b1;
    end else begin
      v.aluop = aop; v.alusrc = asrc; v.extop = aext;
      if (ph == P_EXE && k == K_BEQ) begin
        v.npcop = 2'b01; v.pcwr = z; v.retire = 1'b1;
      end
      if (ph == P_MEM) begin
        v.memrd = (k == K_LW);
        v.memwr = (k == K_SW);
        v.retire = (k == K_SW) && rdy;
      end
      if (ph == P_WB) begin
        v.regwr = 1'b1; v.retire = 1'b1;
        v.regdst = (k == K_ADDU || k == K_SUBU || k == K_SLT);
        v.memtoreg = (k == K_LW);
      end
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs_main", 32'(act_a), 32'(exp_v));
      check("outputs_cnt4", 32'(act_b), 32'(exp_v));
      check("retire_cnt_main", a_cnt, exp_cnt);
      check("retire_cnt_cnt4", 32'(b_cnt), {28'd0, exp_cnt[3:0]});
    end
  end

  task automatic cyc(input kind_t k, input int ph, input logic z, input logic rdy);
    zero = z;
    mem_rdy = rdy;
    exp_v = model(k, ph, z, rdy);
    chk_en = 1'b1;
    @(posedge clk);
    if (exp_v.retire) exp_cnt = exp_cnt + 32'd1;
    #1;
    ncyc++;
  endtask

  task automatic do_instr(input string name, input kind_t k, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input int fstall, input int mstall, input int exp_cycles);
    op = o; funct = f; ncyc = 0;
    repeat (fstall) cyc(k, P_FETCH, z, 1'b0);
    cyc(k, P_FETCH, z, 1'b1);
    cyc(k, P_DECODE, z, 1'b1);
    if (k != K_J && k != K_ILL) begin
      cyc(k, P_EXE, z, 1'b1);
      if (k != K_BEQ) begin
        if (k == K_LW || k == K_SW) begin
          repeat (mstall) cyc(k, P_MEM, z, 1'b0);
          cyc(k, P_MEM, z, 1'b1);
        end
        if (k != K_SW) cyc(k, P_WB, z, 1'b1);
      end
    end
    check({name, "_cycles"}, 32'(ncyc), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op = 6'b000010;
    mem_rdy = 1'b1;
    #12;
    check("reset_outputs", 32'(act_a), 32'd0);
    check("reset_outputs_cnt4", 32'(act_b), 32'd0);
    check("reset_cnt", a_cnt, 32'd0);
    #5 rst_n = 1'b1;

    do_instr("addu",  K_ADDU,  6'b000000, 6'b100001, 1'b0, 0, 0, 4);
    check("cnt_after_addu", a_cnt, 32'd1);
    do_instr("lw",    K_LW,    6'b100011, 6'b000000, 1'b0, 0, 2, 7);
    do_instr("beq_t", K_BEQ,   6'b000100, 6'b000000, 1'b1, 0, 0, 3);
    do_instr("beq_n", K_BEQ,   6'b000100, 6'b000000, 1'b0, 0, 0, 3);
    do_instr("ori",   K_ORI,   6'b001101, 6'b000000, 1'b0, 0, 0, 4);
    do_instr("j",     K_J,     6'b000010, 6'b000000, 1'b0, 0, 0, 2);
    check("cnt_before_ill", a_cnt, 32'd6);
    do_instr("ill_op", K_ILL,  6'b111111, 6'b000000, 1'b0, 0, 0, 2);
    do_instr("ill_fn", K_ILL,  6'b000000, 6'b000000, 1'b0, 0, 0, 2);
    check("cnt_after_ill", a_cnt, 32'd6);
    do_instr("subu",  K_SUBU,  6'b000000, 6'b100011, 1'b0, 0, 0, 4);
    do_instr("slt",   K_SLT,   6'b000000, 6'b101010, 1'b0, 0, 0, 4);
    do_instr("addiu", K_ADDIU, 6'b001001, 6'b000000, 1'b0, 1, 0, 5);
    do_instr("lui",   K_LUI,   6'b001111, 6'b000000, 1'b0, 0, 0, 4);
    do_instr("sw",    K_SW,    6'b101011, 6'b000000, 1'b0, 0, 1, 5);
    check("cnt_after_seq", a_cnt, 32'd11);

    // sw stalled in MEM, then reset asserted between clock edges
    op = 6'b101011; funct = 6'd0;
    cyc(K_SW, P_FETCH, 1'b0, 1'b1);
    cyc(K_SW, P_DECODE, 1'b0, 1'b1);
    cyc(K_SW, P_EXE, 1'b0, 1'b1);
    mem_rdy = 1'b0;
    exp_v = model(K_SW, P_MEM, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_en = 1'b0;
    check("sw_memwr_before_rst", 32'(a_memwr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_memwr_async", 32'(a_memwr), 32'd0);
    check("rst_state_async", 32'(a_state), 32'd0);
    check("rst_all_outputs", 32'(act_a), 32'd0);
    check("rst_cnt", a_cnt, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    exp_cnt = 32'd0;
    check("state_after_release", 32'(a_state), 32'd0);

    for (int i = 0; i < 16; i++)
      do_instr("j_wrap", K_J, 6'b000010, 6'b000000, 1'b0, 0, 0, 2);
    chk_en = 1'b0;
    check("cnt_main_16", a_cnt, 32'd16);
    check("cnt4_wrapped", 32'(b_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
